logic_fu_ctrl: RTL and testbench

Issue controller for the Tomasulo logic functional unit. It arbitrates round-robin among NUM_RS logic reservation-station entries and dispatches one ready entry per cycle into the 32-bit bitwise datapath (AND/OR/XOR/NOT). Results are held in a 2-entry output buffer and broadcast on the CDB under a REQ/GNT handshake. It sits between the logic reservation stations and the CDB arbiter.

---
 rtl/logic_fu_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/logic_fu_ctrl.sv | 142 ++++++++++++++
 tb/tb_logic_fu_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_fu_pkg.sv
// Shared constants for the logic functional-unit issue controller.
package logic_fu_pkg;

  // Bitwise opcodes carried by each reservation-station entry.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;  // uses VJ only

  // Default datapath and tag widths.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;

  // Depth of the result buffer in front of the CDB.
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the scan starts at the pointer and wraps modulo N.
// The pointer moves past the winner only when the caller takes the grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               sum;

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // Pointer register: moves to the entry after the winner on a taken grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/logic_fu_ctrl.sv
// Issue controller for the Tomasulo logic functional unit: picks one ready
// reservation-station entry per cycle, computes its bitwise result and
// queues {tag,result} in a 2-entry buffer that is broadcast on the CDB.
//
// CDB handshake: CDB_REQ is the valid for the buffer head and CDB_GNT is the
// ready; a result transfers on a cycle where both are high. While CDB_REQ is
// high and CDB_GNT is low, CDB_TAG/CDB_DATA stay unchanged. With CDB_REQ low
// the tag/data lines carry stale values and must be ignored.
module logic_fu_ctrl
  import logic_fu_pkg::*;
#(
  parameter int NUM_RS = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic [NUM_RS-1:0]        RS_READY,
  input  logic [2*NUM_RS-1:0]      RS_OP,
  input  logic [DATA_W*NUM_RS-1:0] RS_VJ,
  input  logic [DATA_W*NUM_RS-1:0] RS_VK,
  input  logic [TAG_W*NUM_RS-1:0]  RS_TAG,
  output logic [NUM_RS-1:0]        RS_GRANT,
  output logic                     CDB_REQ,
  input  logic                     CDB_GNT,
  output logic [TAG_W-1:0]         CDB_TAG,
  output logic [DATA_W-1:0]        CDB_DATA,
  output logic                     FU_FULL
);

  logic [1:0]        count;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_data;
  logic [TAG_W-1:0]  tail_tag;
  logic [DATA_W-1:0] tail_data;

  logic              pop;
  logic              push;
  logic              can_issue;
  logic [NUM_RS-1:0] arb_gnt;

  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_vj;
  logic [DATA_W-1:0] sel_vk;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] result;

  assign CDB_REQ  = (count != 2'd0);
  assign FU_FULL  = (count == 2'(BUF_DEPTH));
  assign CDB_TAG  = head_tag;
  assign CDB_DATA = head_data;

  assign pop       = CDB_REQ & CDB_GNT;
  assign can_issue = ~FLUSH & ((count < 2'(BUF_DEPTH)) | pop);

  rr_arbiter #(.N(NUM_RS)) u_arb (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req     (RS_READY),
    .advance (can_issue),
    .gnt     (arb_gnt)
  );

  // Grants are suppressed while reset is asserted so the RS never deallocates.
  assign RS_GRANT = arb_gnt & {NUM_RS{can_issue & RST_N}};
  assign push     = |RS_GRANT;

  // Route the winning entry's fields to the datapath.
  always_comb begin
    sel_op  = '0;
    sel_vj  = '0;
    sel_vk  = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (arb_gnt[i]) begin
        sel_op  = RS_OP[2*i +: 2];
        sel_vj  = RS_VJ[DATA_W*i +: DATA_W];
        sel_vk  = RS_VK[DATA_W*i +: DATA_W];
        sel_tag = RS_TAG[TAG_W*i +: TAG_W];
      end
    end
  end

  // Bitwise datapath.
  always_comb begin
    result = '0;
    case (sel_op)
      OP_AND:  result = sel_vj & sel_vk;
      OP_OR:   result = sel_vj | sel_vk;
      OP_XOR:  result = sel_vj ^ sel_vk;
      default: result = ~sel_vj;
    endcase
  end

  // Result buffer: head slot drives the CDB, tail slot holds the second entry.
  // The head keeps its last value when the buffer drains or is flushed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= 2'd0;
      head_tag  <= '0;
      head_data <= '0;
      tail_tag  <= '0;
      tail_data <= '0;
    end else if (FLUSH) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_tag  <= sel_tag;
            head_data <= result;
          end else begin
            tail_tag  <= sel_tag;
            tail_data <= result;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_tag  <= sel_tag;
            head_data <= result;
          end else begin
            head_tag  <= tail_tag;
            head_data <= tail_data;
            tail_tag  <= sel_tag;
            tail_data <= result;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_tag  <= tail_tag;
            head_data <= tail_data;
          end
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_fu_ctrl.sv
// Self-checking bench for logic_fu_ctrl: opcode vector table, hand-written
// handshake/flush/reset sequences, and a randomized run against a queue model.
module tb_logic_fu_ctrl;

  localparam int N      = 3;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                CLK;
  logic                RST_N;
  logic                FLUSH;
  logic [N-1:0]        RS_READY;
  logic [2*N-1:0]      RS_OP;
  logic [DATA_W*N-1:0] RS_VJ;
  logic [DATA_W*N-1:0] RS_VK;
  logic [TAG_W*N-1:0]  RS_TAG;
  logic [N-1:0]        RS_GRANT;
  logic                CDB_REQ;
  logic                CDB_GNT;
  logic [TAG_W-1:0]    CDB_TAG;
  logic [DATA_W-1:0]   CDB_DATA;
  logic                FU_FULL;

  logic_fu_ctrl #(.NUM_RS(N), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .FLUSH    (FLUSH),
    .RS_READY (RS_READY),
    .RS_OP    (RS_OP),
    .RS_VJ    (RS_VJ),
    .RS_VK    (RS_VK),
    .RS_TAG   (RS_TAG),
    .RS_GRANT (RS_GRANT),
    .CDB_REQ  (CDB_REQ),
    .CDB_GNT  (CDB_GNT),
    .CDB_TAG  (CDB_TAG),
    .CDB_DATA (CDB_DATA),
    .FU_FULL  (FU_FULL)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int total  = 0;
  int passed = 0;

  logic [TAG_W+DATA_W-1:0] exp_q[$];
  int                      ptr;
  logic [TAG_W-1:0]        exp_tag;
  logic [DATA_W-1:0]       exp_data;

  typedef struct {
    logic [N-1:0]      gnt;
    logic              req;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              full;
  } obs_t;

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [DATA_W-1:0] ref_op(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    ptr      = 0;
    exp_tag  = '0;
    exp_data = '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_entry(input int i, input logic [1:0] op, input logic [DATA_W-1:0] vj,
                           input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] tag);
    RS_OP[2*i +: 2]           = op;
    RS_VJ[DATA_W*i +: DATA_W] = vj;
    RS_VK[DATA_W*i +: DATA_W] = vk;
    RS_TAG[TAG_W*i +: TAG_W]  = tag;
  endtask

  // One cycle: inputs are already driven; sample and check at the negedge,
  // advance the model with the rules, then return 1 time unit after posedge.
  task automatic step(output obs_t o);
    int           win;
    logic [N-1:0] eg;
    bit           popv;
    bit           can;
    logic [DATA_W-1:0] res;
    @(negedge CLK);
    o.gnt  = RS_GRANT;
    o.req  = CDB_REQ;
    o.tag  = CDB_TAG;
    o.data = CDB_DATA;
    o.full = FU_FULL;
    popv = (exp_q.size() != 0) && CDB_GNT;
    can  = !FLUSH && ((exp_q.size() < 2) || popv);
    win  = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (win < 0 && RS_READY[i]) win = i;
    end
    eg = '0;
    if (can && win >= 0) eg[win] = 1'b1;
    check("rs_grant", 64'(RS_GRANT), 64'(eg));
    check("cdb_req", 64'(CDB_REQ), 64'(exp_q.size() != 0));
    check("cdb_tag", 64'(CDB_TAG), 64'(exp_tag));
    check("cdb_data", 64'(CDB_DATA), 64'(exp_data));
    check("fu_full", 64'(FU_FULL), 64'(exp_q.size() == 2));
    if (FLUSH) begin
      exp_q.delete();
    end else begin
      if (popv) void'(exp_q.pop_front());
      if (eg != '0) begin
        res = ref_op(RS_OP[2*win +: 2], RS_VJ[DATA_W*win +: DATA_W], RS_VK[DATA_W*win +: DATA_W]);
        exp_q.push_back({RS_TAG[TAG_W*win +: TAG_W], res});
        ptr = (win + 1) % N;
      end
    end
    if (exp_q.size() != 0) {exp_tag, exp_data} = exp_q[0];
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    FLUSH    = 1'b0;
    CDB_GNT  = 1'b0;
    RS_READY = '1;
    model_reset();
    @(negedge CLK);
    check("rst_grant", 64'(RS_GRANT), 64'(0));
    check("rst_req", 64'(CDB_REQ), 64'(0));
    check("rst_tag", 64'(CDB_TAG), 64'(0));
    check("rst_data", 64'(CDB_DATA), 64'(0));
    check("rst_full", 64'(FU_FULL), 64'(0));
    @(posedge CLK);
    #1;
    RST_N    = 1'b1;
    RS_READY = '0;
  endtask

  // ---------------- test ----------------
  obs_t o;
  vec_t vecs[6];
  logic [N-1:0]     rr_exp[4];
  logic [TAG_W-1:0] rr_tag[4];

  initial begin
    vecs[0] = '{2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[1] = '{2'd3, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000};
    vecs[2] = '{2'd1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
    vecs[3] = '{2'd2, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vecs[4] = '{2'd0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[5] = '{2'd3, 32'h80000001, 32'hFFFFFFFF, 32'h7FFFFFFE};
    rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_tag  = '{4'd1, 4'd2, 4'd3, 4'd1};

    RS_OP = '0; RS_VJ = '0; RS_VK = '0; RS_TAG = '0;
    #1;
    do_reset();

    // Opcode table through entry 0: grant in cycle N, result in cycle N+1.
    for (int v = 0; v < 6; v++) begin
      set_entry(0, vecs[v].op, vecs[v].vj, vecs[v].vk, TAG_W'(v + 5));
      RS_READY = 3'b001;
      CDB_GNT  = 1'b1;
      step(o);
      check("vec_grant", 64'(o.gnt), 64'(3'b001));
      RS_READY = 3'b000;
      step(o);
      check("vec_req", 64'(o.req), 64'(1));
      check("vec_tag", 64'(o.tag), 64'(v + 5));
      check("vec_data", 64'(o.data), 64'(vecs[v].exp));
    end
    step(o);

    // Round-robin with all entries ready and the CDB always granting.
    do_reset();
    for (int i = 0; i < N; i++) set_entry(i, 2'd1, 32'h1 << i, 32'h0, TAG_W'(i + 1));
    RS_READY = 3'b111;
    CDB_GNT  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(o);
      check("rr_grant", 64'(o.gnt), 64'(rr_exp[s]));
      if (s > 0) check("rr_tag", 64'(o.tag), 64'(rr_tag[s-1]));
    end
    RS_READY = 3'b000;
    step(o);
    check("rr_last_tag", 64'(o.tag), 64'(rr_tag[3]));
    step(o);

    // Backpressure: fill the buffer, then one simultaneous pop and grant.
    do_reset();
    for (int i = 0; i < N; i++) set_entry(i, 2'd2, 32'h11 << (4*i), 32'h0, TAG_W'(8 + i));
    RS_READY = 3'b011;
    CDB_GNT  = 1'b0;
    step(o); check("bp_g0", 64'(o.gnt), 64'(3'b001));
    step(o); check("bp_g1", 64'(o.gnt), 64'(3'b010));
    step(o); check("bp_g2", 64'(o.gnt), 64'(3'b000));
    check("bp_full", 64'(o.full), 64'(1));
    check("bp_head", 64'(o.tag), 64'(8));
    CDB_GNT = 1'b1;
    step(o); check("bp_popgrant", 64'(o.gnt), 64'(3'b001));
    CDB_GNT  = 1'b0;
    RS_READY = 3'b000;
    step(o);
    check("bp_still_full", 64'(o.full), 64'(1));
    check("bp_adv_tag", 64'(o.tag), 64'(9));
    check("bp_adv_data", 64'(o.data), 64'(32'h00000110));

    // Hold stability: one result parked with the CDB refusing for 5 cycles.
    do_reset();
    set_entry(0, 2'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'd9);
    RS_READY = 3'b001;
    step(o);
    RS_READY = 3'b000;
    for (int s = 0; s < 5; s++) begin
      step(o);
      check("hold_req", 64'(o.req), 64'(1));
      check("hold_tag", 64'(o.tag), 64'(9));
      check("hold_data", 64'(o.data), 64'(32'hAAAAAAAA));
    end

    // Flush with a full buffer and all entries ready; pointer must not move.
    RS_READY = 3'b011;
    step(o); check("fl_fill", 64'(o.gnt), 64'(3'b010));
    RS_READY = 3'b111;
    FLUSH    = 1'b1;
    CDB_GNT  = 1'b1;
    step(o); check("fl_nogrant", 64'(o.gnt), 64'(0));
    FLUSH    = 1'b0;
    CDB_GNT  = 1'b0;
    RS_READY = 3'b000;
    step(o); check("fl_empty", 64'(o.req), 64'(0));
    RS_READY = 3'b111;
    step(o); check("fl_ptr_kept", 64'(o.gnt), 64'(3'b100));

    // Asynchronous reset in the middle of a cycle with work buffered.
    RST_N = 1'b0;
    #1;
    check("arst_req", 64'(CDB_REQ), 64'(0));
    check("arst_tag", 64'(CDB_TAG), 64'(0));
    check("arst_data", 64'(CDB_DATA), 64'(0));
    check("arst_full", 64'(FU_FULL), 64'(0));
    check("arst_grant", 64'(RS_GRANT), 64'(0));
    do_reset();

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        set_entry(i, 2'($urandom_range(0, 3)), $urandom, $urandom, TAG_W'($urandom_range(0, 15)));
      RS_READY = N'($urandom_range(0, 7));
      CDB_GNT  = ($urandom_range(0, 3) != 0);
      FLUSH    = ($urandom_range(0, 19) == 0);
      step(o);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
